// File: rtl/cook_timer_pkg.sv
// -----------------------------------------------------------------------------
// cook_timer_pkg
// Shared definitions for the cook timer controller:
//   - FSM state encoding (also driven out on state_o for display/debug)
//   - BCD digit / entry widths and the bit offsets of each digit in the entry
//   - sec_tens clamp value and the largest legal keypad digit
//   - secs_to_bcd(): converts a seconds count into the {min, tens, ones} BCD form
// -----------------------------------------------------------------------------
package cook_timer_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int ENTRY_W    = DIGIT_W * NUM_DIGITS;

    // Digit positions inside the 12-bit entry / cnt_data word
    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Seconds -> {min_ones, sec_tens, sec_ones}; minutes beyond 9 wrap.
    function automatic logic [ENTRY_W-1:0] secs_to_bcd(input int unsigned secs);
        int unsigned mins;
        int unsigned rem;
        mins = secs / 60;
        rem  = secs % 60;
        secs_to_bcd = {DIGIT_W'(mins % 10), DIGIT_W'(rem / 10), DIGIT_W'(rem % 10)};
    endfunction

endpackage

// File: rtl/cook_timer_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider used while cooking. Counts 0..TICK_DIV-1 while run=1,
// pulses tick during the terminal-count cycle and wraps to 0. Holds its count
// when run=0 so a paused cook resumes mid-second; clr forces the count to 0.
//
// Ports:
//   clk   in   system clock, rising edge
//   clrn  in   asynchronous active-low reset
//   clr   in   synchronous clear of the count (wins over run)
//   run   in   advance the count this cycle
//   tick  out  high in the cycle the count sits at TICK_DIV-1 with run=1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = run && (count_q == TERM);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// -----------------------------------------------------------------------------
// cook_timer_ctrl
// Oven controller FSM sequencing a BCD countdown chain (min_ones, sec_tens,
// sec_ones). Collects keypad digits into a 3-digit entry, parallel-loads the
// chain, issues one cnt_en per second while cooking, and handles pause/resume,
// door interlock, clear and the cook-complete indication.
//
// Build option: define QUICK_START_EN to let start in IDLE (or in SET with an
// all-zero entry) load QUICK_SECS and begin cooking immediately.
//
// Ports:
//   clk           in   system clock, rising edge
//   clrn          in   asynchronous active-low reset
//   key_valid     in   one-cycle pulse, key_digit valid
//   key_digit     in   [3:0] BCD keypad digit (values >9 ignored)
//   start         in   one-cycle start button pulse
//   stop          in   one-cycle stop button pulse
//   clear         in   one-cycle clear button pulse
//   door_closed   in   level, 1 = door latched
//   timer_zero    in   all three chain counters at zero
//   load_n        out  active-low parallel load to the chain
//   cnt_data      out  [11:0] {min_ones, sec_tens, sec_ones} load value
//   cnt_en        out  one-cycle count-down enable
//   magnetron_on  out  heater enable
//   done          out  cook-complete indicator
//   state_o       out  [2:0] current FSM state
// -----------------------------------------------------------------------------
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DONE_CYCLES = 3,
    parameter int QUICK_SECS  = 30
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               load_n,
    output logic [ENTRY_W-1:0] cnt_data,
    output logic               cnt_en,
    output logic               magnetron_on,
    output logic               done,
    output logic [2:0]         state_o
);

`ifdef QUICK_START_EN
    localparam bit QUICK_EN = 1'b1;
`else
    localparam bit QUICK_EN = 1'b0;
`endif

    localparam logic [ENTRY_W-1:0] QUICK_ENTRY = secs_to_bcd(QUICK_SECS);
    localparam int                 DONE_W      = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [DONE_W-1:0]  DONE_LAST   = DONE_W'(DONE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [DONE_W-1:0]  done_cnt_q, done_cnt_d;
    logic               pend_q, pend_d;

    logic door_open;
    logic hold_req;
    logic key_ok;
    logic quick_ok;
    logic done_expired;
    logic pre_clr;
    logic pre_run;
    logic pre_tick;

    // -------------------------------------------------------------------------
    // Next-state logic. Each state tests its events in the fixed priority
    // clear > stop/door open > start > key_valid, so a higher event always
    // masks the lower ones even when it causes no transition itself.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        done_cnt_d   = '0;
        pend_d       = 1'b0;
        door_open    = !door_closed;
        hold_req     = stop || door_open;
        key_ok       = key_valid && (key_digit <= DIGIT_MAX);
        quick_ok     = QUICK_EN && door_closed && (entry_q == '0);
        done_expired = (done_cnt_q == DONE_LAST);

        case (state_q)
            ST_IDLE, ST_SET: begin
                if (clear) begin
                    entry_d = '0;
                    state_d = ST_IDLE;
                end else if (hold_req) begin
                    // door open / stop: no entry activity
                end else if (start) begin
                    if ((state_q == ST_SET) && (entry_q != '0)) begin
                        state_d = ST_LOAD;
                    end else if (quick_ok) begin
                        entry_d = QUICK_ENTRY;
                        state_d = ST_LOAD;
                    end
                end else if (key_ok) begin
                    // new digit enters at sec_ones, old min_ones falls off
                    entry_d = {entry_q[ENTRY_W-DIGIT_W-1:0], key_digit};
                    state_d = ST_SET;
                end
            end

            ST_LOAD: begin
                if (clear) begin
                    entry_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    // a door opened here is caught by COOK on the next cycle
                    state_d = ST_COOK;
                end
            end

            ST_COOK: begin
                if (clear) begin
                    entry_d = '0;
                    state_d = ST_IDLE;
                end else if (hold_req) begin
                    state_d = ST_PAUSE;
                end else if (timer_zero) begin
                    state_d = ST_DONE;
                end
            end

            ST_PAUSE: begin
                if (clear) begin
                    entry_d = '0;
                    state_d = ST_IDLE;
                end else if (hold_req) begin
                    // stay paused
                end else if (start) begin
                    state_d = ST_COOK;
                end
            end

            ST_DONE: begin
                if (done_expired) begin
                    done_cnt_d = done_cnt_q;
                    if (pend_q || clear || door_open) begin
                        entry_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // exit requests during the minimum done time are remembered
                    done_cnt_d = done_cnt_q + 1'b1;
                    pend_d     = pend_q || clear || door_open;
                end
            end

            default: begin
                entry_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The prescaler only advances in cycles where COOK is kept, so a
        // pause freezes it at exactly the count it had reached.
        pre_clr = (state_q == ST_LOAD);
        pre_run = (state_q == ST_COOK) && !clear && !hold_req && !timer_zero;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            done_cnt_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            done_cnt_q <= done_cnt_d;
            pend_q     <= pend_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .clrn (clrn),
        .clr  (pre_clr),
        .run  (pre_run),
        .tick (pre_tick)
    );

    // -------------------------------------------------------------------------
    // Outputs. All decode directly from reset flops, so they fall to their
    // idle values the moment clrn asserts.
    // -------------------------------------------------------------------------
    always_comb begin
        load_n       = (state_q != ST_LOAD);
        magnetron_on = (state_q == ST_COOK);
        done         = (state_q == ST_DONE);
        cnt_en       = pre_tick;  // pre_run already excludes timer_zero
        state_o      = state_q;
    end

    // Load value per digit; only sec_tens is clamped so the chain never sees
    // an illegal mod-6 value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] digit;
            assign digit = entry_q[gi*DIGIT_W +: DIGIT_W];
            if (gi * DIGIT_W == SEC_TENS_LSB) begin : g_clamp
                assign cnt_data[gi*DIGIT_W +: DIGIT_W] =
                    (digit > SEC_TENS_MAX) ? SEC_TENS_MAX : digit;
            end else begin : g_pass
                assign cnt_data[gi*DIGIT_W +: DIGIT_W] = digit;
            end
        end
    endgenerate

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cook_timer_ctrl
// Self-checking bench for cook_timer_ctrl with TICK_DIV=4. A behavioural
// BCD down-counter chain closes the loop on load_n/cnt_data/cnt_en and drives
// timer_zero. Digit-entry cases come from a vector table whose expected load
// values pass through a scoreboard queue; cook, pause, done and reset cases are
// hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cook_timer_ctrl;
    import cook_timer_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int DONE_CYCLES = 3;
    localparam int QUICK_SECS  = 30;

    logic        clk = 1'b0;
    logic        clrn;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        clear;
    logic        door_closed;
    logic        timer_zero;
    logic        load_n;
    logic [11:0] cnt_data;
    logic        cnt_en;
    logic        magnetron_on;
    logic        done;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cook_timer_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DONE_CYCLES (DONE_CYCLES),
        .QUICK_SECS  (QUICK_SECS)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .load_n       (load_n),
        .cnt_data     (cnt_data),
        .cnt_en       (cnt_en),
        .magnetron_on (magnetron_on),
        .done         (done),
        .state_o      (state_o)
    );

    // ---------------- counter chain model ----------------
    logic [3:0] m_min, m_tens, m_ones;
    logic       zero_en_seen = 1'b0;
    int         en_total     = 0;
    int         load_total   = 0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_min  <= 4'd0;
            m_tens <= 4'd0;
            m_ones <= 4'd0;
        end else if (!load_n) begin
            {m_min, m_tens, m_ones} <= cnt_data;
        end else if (cnt_en) begin
            if (m_ones != 4'd0) begin
                m_ones <= m_ones - 4'd1;
            end else begin
                m_ones <= 4'd9;
                if (m_tens != 4'd0) begin
                    m_tens <= m_tens - 4'd1;
                end else begin
                    m_tens <= 4'd5;
                    m_min  <= (m_min == 4'd0) ? 4'd9 : m_min - 4'd1;
                end
            end
        end
    end

    assign timer_zero = (m_min == 4'd0) && (m_tens == 4'd0) && (m_ones == 4'd0);

    always @(posedge clk) begin
        if (clrn && cnt_en && timer_zero) zero_en_seen <= 1'b1;
        if (clrn && cnt_en)  en_total   <= en_total + 1;
        if (clrn && !load_n) load_total <= load_total + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // ---------------- entry vectors + scoreboard ----------------
    typedef struct packed {
        logic [15:0] keys;   // first key in the top nibble
        logic [2:0]  n;
        logic [11:0] exp;    // expected cnt_data
    } vec_t;

    vec_t        vecs [6];
    logic [11:0] exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first;
        int   ticks;
        int   cyc;
        int   en_snap;
        int   load_snap;
        logic [11:0] e;
        logic [15:0] kw;

        vecs[0] = '{keys: 16'h1250, n: 3'd3, exp: 12'h125};
        vecs[1] = '{keys: 16'h0990, n: 3'd3, exp: 12'h059};
        vecs[2] = '{keys: 16'h1234, n: 3'd4, exp: 12'h234};
        vecs[3] = '{keys: 16'h123B, n: 3'd4, exp: 12'h123};
        vecs[4] = '{keys: 16'h9990, n: 3'd3, exp: 12'h959};
        vecs[5] = '{keys: 16'h7000, n: 3'd1, exp: 12'h007};

        clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",     32'(state_o),      32'd0);
        check("reset_load_n",    32'(load_n),       32'd1);
        check("reset_cnt_en",    32'(cnt_en),       32'd0);
        check("reset_magnetron", 32'(magnetron_on), 32'd0);
        check("reset_done",      32'(done),         32'd0);
        check("reset_cnt_data",  32'(cnt_data),     32'h0);
        @(negedge clk);
        clrn = 1'b1;
        step();

        // start in IDLE
`ifdef QUICK_START_EN
        pulse_start();
        check("quick_state_load", 32'(state_o),  32'd2);
        check("quick_cnt_data",   32'(cnt_data), 32'h030);
        step();
        check("quick_state_cook", 32'(state_o),  32'd3);
        pulse_clear();
        check("quick_clear_idle", 32'(state_o),  32'd0);
`else
        pulse_start();
        check("idle_start_ignored", 32'(state_o), 32'd0);
        check("idle_start_no_load", 32'(load_n),  32'd1);
`endif

        // digit entry table
        for (int i = 0; i < 6; i++) begin
            pulse_clear();
            kw = vecs[i].keys;
            exp_q.push_back(vecs[i].exp);
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                press(kw[15-4*k -: 4]);
            end
            if (exp_q.size() == 0) begin
                check("entry_scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("entry_vec%0d_cnt_data", i), 32'(cnt_data), 32'(e));
                check($sformatf("entry_vec%0d_state", i),    32'(state_o),  32'd1);
            end
        end

        // full cook 1:25 -> done
        pulse_clear();
        press(4'd1); press(4'd2); press(4'd5);
        pulse_start();
        check("cook_load_state",  32'(state_o),  32'd2);
        check("cook_load_n",      32'(load_n),   32'd0);
        check("cook_load_data",   32'(cnt_data), 32'h125);
        step();
        check("cook_state",       32'(state_o),      32'd3);
        check("cook_magnetron",   32'(magnetron_on), 32'd1);
        check("cook_chain_load",  32'({m_min, m_tens, m_ones}), 32'h125);
        first = -1; ticks = 0; cyc = 0;
        while (state_o == 3'd3 && cyc < 1000) begin
            if (cnt_en) begin
                if (first < 0) first = cyc;
                ticks++;
            end
            step();
            cyc++;
        end
        check("cook_first_tick_cycle", 32'(first), 32'(TICK_DIV - 1));
        check("cook_tick_count",       32'(ticks), 32'd85);
        check("done_state",            32'(state_o),      32'd5);
        check("done_flag",             32'(done),         32'd1);
        check("done_magnetron_off",    32'(magnetron_on), 32'd0);
        step();                                    // done cycle 1
        check("done_c1_state", 32'(state_o), 32'd5);
        pulse_clear();                             // clear in cycle 1 -> cycle 2
        check("done_c2_held",  32'(done),    32'd1);
        step();                                    // cycle 3
        check("done_c3_idle",  32'(state_o), 32'd0);
        check("done_c3_entry", 32'(cnt_data), 32'h0);

        // pause / resume
        pulse_clear();
        press(4'd2);
        pulse_start();
        step();                                    // COOK, prescaler 0
        step();                                    // 1
        step();                                    // 2
        en_snap = en_total;
        door_closed = 1'b0;
        step();
        check("pause_state",      32'(state_o),      32'd4);
        check("pause_magnetron",  32'(magnetron_on), 32'd0);
        repeat (3) step();
        check("pause_no_ticks",   32'(en_total - en_snap), 32'd0);
        load_snap = load_total;
        door_closed = 1'b1;
        pulse_start();
        check("resume_state",     32'(state_o), 32'd3);
        check("resume_r0_no_en",  32'(cnt_en),  32'd0);
        step();
        check("resume_r1_en",     32'(cnt_en),  32'd1);
        step();
        check("resume_no_reload", 32'(load_total - load_snap), 32'd0);
        check("resume_chain",     32'({m_min, m_tens, m_ones}), 32'h001);
        pulse_clear();
        check("cook_clear_idle",  32'(state_o),  32'd0);
        check("cook_clear_entry", 32'(cnt_data), 32'h0);

        // SET corner cases
        press(4'd4);
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        check("set_start_clear_state", 32'(state_o),  32'd0);
        check("set_start_clear_entry", 32'(cnt_data), 32'h0);
        check("set_start_clear_noload", 32'(load_n), 32'd1);
        press(4'd4);
        door_closed = 1'b0;
        pulse_start();
        check("set_door_open_start", 32'(state_o), 32'd1);
        door_closed = 1'b1;

        // asynchronous reset while cooking
        pulse_start();
        step();
        step();
        check("pre_reset_magnetron", 32'(magnetron_on), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check("rst_mid_state",     32'(state_o),      32'd0);
        check("rst_mid_magnetron", 32'(magnetron_on), 32'd0);
        check("rst_mid_load_n",    32'(load_n),       32'd1);
        check("rst_mid_cnt_en",    32'(cnt_en),       32'd0);
        check("rst_mid_cnt_data",  32'(cnt_data),     32'h0);
        @(negedge clk);
        clrn = 1'b1;
        step();

        check("no_cnt_en_at_zero", 32'(zero_en_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
Controller FSM that sequences the oven's countdown chain: minutes ones, seconds tens (mod 6) and seconds ones (mod 10) down-counters.
- Collects keypad digits into a 3-digit entry register, loads it into the counters and issues one count-enable per second while cooking.
- Handles pause/resume, door interlock and clear, and drives the magnetron and done outputs.
- Sits between the keypad/button debouncers and the counter chain.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s count tick (bench uses 4)
DONE_CYCLES, 3, cycles done stays high before the controller waits for clear or door open
QUICK_SECS, 30, seconds loaded by quick start, BCD 0:30 (used only with QUICK_START_EN)

Ports:
clk  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse; key_digit is valid
key_digit  in  4  BCD digit from keypad
start  in  1  one-cycle pulse, debounced start button
stop  in  1  one-cycle pulse, debounced stop button
clear  in  1  one-cycle pulse, debounced clear button
door_closed  in  1  level, 1 = door latched
timer_zero  in  1  AND of the three counters' zero flags
load_n  out  1  active-low parallel load to all three counters
cnt_data  out  12  {min_ones, sec_tens, sec_ones} BCD load value
cnt_en  out  1  one-cycle count-down enable to the chain
magnetron_on  out  1  heater enable
done  out  1  cook-complete indicator
state_o  out  3  current FSM state (for display/debug)

Behaviour:
- Reset (clrn=0, async):
  - state=IDLE, entry=0, prescaler=0.
  - load_n=1, cnt_en=0, magnetron_on=0, done=0, cnt_data=0.
- All other logic is synchronous to rising clk. Input priority in every state: clear > stop/door open > start > key_valid.
- Digit entry:
  - In IDLE or SET, key_valid with key_digit<=9 shifts the entry left by one digit (new digit becomes sec_ones; old min_ones is dropped) and moves to SET.
  - key_digit>9 is ignored.
  - key_valid is ignored in all other states.
- cnt_data always reflects entry, except sec_tens, which is clamped to 5 when entry sec_tens>5.
- IDLE: waits for a key.
- SET:
  - clear -> entry=0, IDLE.
  - start with door_closed=1 and entry!=0 -> LOAD.
  - start with door open or entry=0 -> ignored.
- LOAD (exactly 1 cycle): load_n=0, prescaler cleared -> COOK.
- COOK:
  - magnetron_on=1.
  - Prescaler counts 0..TICK_DIV-1. At terminal count, cnt_en=1 for one cycle, but only if timer_zero=0.
  - First tick occurs TICK_DIV cycles after entering COOK from LOAD.
  - timer_zero=1 -> DONE; checked before the tick, so cnt_en is never asserted at zero and the chain never wraps 0->9.
  - stop or door_closed=0 -> PAUSE in the same cycle; magnetron_on drops on that edge.
  - clear -> IDLE, entry=0.
- PAUSE:
  - magnetron_on=0, cnt_en=0, prescaler holds its value.
  - start with door_closed=1 -> COOK, no reload; prescaler resumes.
  - clear -> IDLE, entry=0.
- DONE:
  - done=1, magnetron_on=0; stays DONE_CYCLES minimum.
  - After that, clear or door_closed=0 -> IDLE with entry=0.
  - Events before DONE_CYCLES elapse are held pending and acted on at expiry.
- Simultaneous events:
  - start+stop in COOK -> PAUSE.
  - clear+anything -> clear wins.
  - Door open in LOAD -> load completes, then COOK sees the door open and goes to PAUSE next cycle.
- Reset mid-cook: outputs drop asynchronously; the counters are reset separately by the same clrn.
- state_o encoding: IDLE=0, SET=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.

Optional Feature:
QUICK_START_EN
- Defined: start in IDLE (or in SET with entry=0) with door_closed=1 sets entry=QUICK_SECS as BCD and goes to LOAD. start in COOK raises no change.
- Undefined: start in IDLE is ignored, exactly as specified above.

Decomposition:
- Package cook_timer_pkg:
  - state enum/localparams with the encoding above.
  - BCD digit width (4), entry width (12).
  - Field offsets for min/tens/ones.
  - SEC_TENS_MAX=5.
- One sub-module, tick_prescaler (clk, clrn, clr, run, tick): holds its count when run=0, clears on clr.

Test Plan:
- Keys 1,2,5, start, door closed, TICK_DIV=4 -> LOAD 1 cycle with cnt_data=0x125; magnetron_on=1; first cnt_en 4 cycles after COOK entry; DONE once model counters reach 000; cnt_en never high while timer_zero=1.
- Keys 0,9,9 -> cnt_data=0x059 (tens clamped); keys 1,2,3,4 -> entry 0x234; key_digit=0xB -> entry unchanged.
- During COOK, door_closed=0 at prescaler=2 -> PAUSE next edge, magnetron_on=0; door closed + start -> COOK; next cnt_en exactly 2 cycles later, no load_n pulse.
- start+clear same cycle in SET -> IDLE, entry=0, no LOAD; start with door open in SET -> stays SET.
- Reaching DONE -> done=1 for >=3 cycles; clear pulsed at cycle 1 -> IDLE exactly at cycle 3.
- clrn low mid-COOK -> all outputs 0 (load_n=1) immediately, state_o=0; QUICK_START_EN build: start in IDLE -> cnt_data=0x030, COOK.
